// File: rtl/approx_mult_pkg.sv
// Purpose : shared FSM state encoding and derived-width helpers for approx_mult_stream.
// Latency : n/a (declarations only).
// Backpressure: n/a.
// Contents : state_t (IDLE/NORM/MUL/DENORM/OUT); cnt_w()/rem_w() width helpers;
//            CNT_W/REM_W evaluated for the default configuration (16/8/7).
package approx_mult_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    NORM   = 3'd1,
    MUL    = 3'd2,
    DENORM = 3'd3,
    OUT    = 3'd4
  } state_t;

  // Width of a normalization shift counter able to hold 0..shift_max.
  function automatic int cnt_w(input int shift_max);
    return $clog2(shift_max + 1);
  endfunction

  // Width of the denormalization counter able to hold 0..2*(data_w-keep_w).
  function automatic int rem_w(input int data_w, input int keep_w);
    return $clog2(2 * (data_w - keep_w) + 1);
  endfunction

  localparam int CNT_W = cnt_w(7);
  localparam int REM_W = rem_w(16, 8);

endpackage

// File: rtl/approx_norm_unit.sv
// Purpose : per-operand normalizer: shifts left until MSB set or SHIFT_MAX shifts done.
// Latency : one shift per cycle while step is high; done is combinational.
// Backpressure: none; the owning FSM holds step high only while in NORM.
// Ports   : clk/rst (sync, active-high); load/din start a new operand and clear cnt;
//           step advances one shift when not done; dat/cnt/done expose the state.
module approx_norm_unit
  import approx_mult_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int SHIFT_MAX = 7,
  parameter int CW        = cnt_w(SHIFT_MAX)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dat,
  output logic [CW-1:0]     cnt,
  output logic              done
);

  // A zero operand never sets its MSB, so the count limit is what ends it.
  assign done = dat[DATA_W-1] | (cnt == CW'(SHIFT_MAX));

  always_ff @(posedge clk) begin
    if (rst) begin
      dat <= '0;
      cnt <= '0;
    end else if (load) begin
      dat <= din;
      cnt <= '0;
    end else if (step && !done) begin
      dat <= {dat[DATA_W-2:0], 1'b0};
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/approx_mult_stream.sv
// Purpose : streaming approximate unsigned multiplier (normalize, KEEP_W x KEEP_W multiply, denormalize).
// Latency : (max(sa,sb)+1) + 1 + (rem+1) cycles from accept edge to out_valid; one pair in flight.
// Backpressure: in_ready only in IDLE; result held in OUT until out_ready, no same-cycle re-accept.
// Ports   : clk, rst (sync, active-high); in_valid/in_ready/in_a/in_b operand stream;
//           out_valid/out_ready/out_p result stream; busy high whenever not IDLE.
// Config  : APPROX_MULT_ROUND_EN selects round-half-up (saturating) instead of truncation
//           for the kept operand bits; latency is identical either way.
// Legal   : 0 < SHIFT_MAX <= DATA_W-KEEP_W, which keeps rem non-negative.
module approx_mult_stream
  import approx_mult_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int KEEP_W    = 8,
  parameter int SHIFT_MAX = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_a,
  input  logic [DATA_W-1:0]   in_b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*DATA_W-1:0] out_p,
  output logic                busy
);

  localparam int CW   = cnt_w(SHIFT_MAX);
  localparam int RW   = rem_w(DATA_W, KEEP_W);
  localparam int PW   = 2 * DATA_W;
  localparam int LOSS = DATA_W - KEEP_W;

  state_t state, state_nxt;

  logic [DATA_W-1:0]   reg_a, reg_b;
  logic [CW-1:0]       sa, sb;
  logic                done_a, done_b;
  logic                accept;
  logic [KEEP_W-1:0]   ta, tb;
  logic [2*KEEP_W-1:0] mul;
  logic [PW-1:0]       prod;
  logic [RW-1:0]       rem, rem_init;
  logic                unused_lsbs;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == OUT);
  assign busy      = (state != IDLE);
  assign accept    = in_valid && in_ready;
  assign out_p     = prod;

  approx_norm_unit #(.DATA_W(DATA_W), .SHIFT_MAX(SHIFT_MAX), .CW(CW)) u_norm_a (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .step (state == NORM),
    .din  (in_a),
    .dat  (reg_a),
    .cnt  (sa),
    .done (done_a)
  );

  approx_norm_unit #(.DATA_W(DATA_W), .SHIFT_MAX(SHIFT_MAX), .CW(CW)) u_norm_b (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .step (state == NORM),
    .din  (in_b),
    .dat  (reg_b),
    .cnt  (sb),
    .done (done_b)
  );

`ifdef APPROX_MULT_ROUND_EN
  // Add the first dropped bit; an all-ones field would wrap, so clamp it instead.
  logic [KEEP_W:0] sum_a, sum_b;
  always_comb begin
    sum_a = {1'b0, reg_a[DATA_W-1 -: KEEP_W]} + {{KEEP_W{1'b0}}, reg_a[LOSS-1]};
    sum_b = {1'b0, reg_b[DATA_W-1 -: KEEP_W]} + {{KEEP_W{1'b0}}, reg_b[LOSS-1]};
    ta    = sum_a[KEEP_W] ? {KEEP_W{1'b1}} : sum_a[KEEP_W-1:0];
    tb    = sum_b[KEEP_W] ? {KEEP_W{1'b1}} : sum_b[KEEP_W-1:0];
  end
`else
  assign ta = reg_a[DATA_W-1 -: KEEP_W];
  assign tb = reg_b[DATA_W-1 -: KEEP_W];
`endif

  // Dropped low bits only contribute through the rounding path.
  assign unused_lsbs = ^{reg_a[LOSS-1:0], reg_b[LOSS-1:0]};

  assign mul = {{KEEP_W{1'b0}}, ta} * {{KEEP_W{1'b0}}, tb};

  // Undo the implicit 2*LOSS truncation, less the normalization shifts already applied.
  assign rem_init = RW'(2 * LOSS) - RW'(sa) - RW'(sb);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)         state_nxt = NORM;
      NORM:    if (done_a && done_b) state_nxt = MUL;
      MUL:                           state_nxt = DENORM;
      DENORM:  if (rem == '0)        state_nxt = OUT;
      OUT:     if (out_ready)        state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      prod  <= '0;
      rem   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        MUL: begin
          prod <= {{(PW - 2*KEEP_W){1'b0}}, mul};
          rem  <= rem_init;
        end
        DENORM: begin
          if (rem != '0) begin
            prod <= {prod[PW-2:0], 1'b0};
            rem  <= rem - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_approx_mult_stream.sv
module tb_approx_mult_stream;
  import approx_mult_pkg::*;

  localparam int DW = 16;
  localparam int KW = 8;
  localparam int SM = 7;
  localparam int PW = 2 * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_a, in_b;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_p;
  logic          busy;

  always #5 clk = ~clk;

  approx_mult_stream #(.DATA_W(DW), .KEEP_W(KW), .SHIFT_MAX(SM)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .busy      (busy)
  );

  typedef struct {
    logic [PW-1:0] p;
    int            sa;
    int            sb;
    int            rem;
    int            norm;
    int            lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;
  int   xfers    = 0;

  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) xfers = xfers + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: normalize, keep KW MSBs (optionally rounded), multiply, rescale.
  function automatic exp_t model(input logic [DW-1:0] a, input logic [DW-1:0] b);
    exp_t          e;
    logic [DW-1:0] ra, rb;
    logic [KW:0]   ka, kb;
    logic [63:0]   p64;
    int            s_a, s_b;
    ra = a; rb = b; s_a = 0; s_b = 0;
    while (!ra[DW-1] && s_a < SM) begin ra = ra << 1; s_a++; end
    while (!rb[DW-1] && s_b < SM) begin rb = rb << 1; s_b++; end
    ka = {1'b0, ra[DW-1 -: KW]};
    kb = {1'b0, rb[DW-1 -: KW]};
`ifdef APPROX_MULT_ROUND_EN
    if (ra[DW-1-KW] && ka != {1'b0, {KW{1'b1}}}) ka = ka + 1'b1;
    if (rb[DW-1-KW] && kb != {1'b0, {KW{1'b1}}}) kb = kb + 1'b1;
`endif
    p64    = (64'(ka) * 64'(kb)) << (2 * (DW - KW));
    p64    = p64 >> (s_a + s_b);
    e.p    = p64[PW-1:0];
    e.sa   = s_a;
    e.sb   = s_b;
    e.rem  = 2 * (DW - KW) - s_a - s_b;
    e.norm = ((s_a > s_b) ? s_a : s_b) + 1;
    e.lat  = e.norm + 1 + e.rem + 1;
    return e;
  endfunction

  // Push one pair, wait for its result, hold out_ready low for 'hold' cycles, then take it.
  task automatic run_pair(input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input int hold, output logic [PW-1:0] got);
    exp_t          e;
    int            guard, lat, norm, rem_seen, x0;
    logic [PW-1:0] first;
    guard = 0;
    while (!in_ready && guard < 50) begin @(posedge clk); #1; guard++; end
    chk("in_ready_before_push", in_ready, 1'b1);
    in_a = a; in_b = b; in_valid = 1'b1;
    sb_q.push_back(model(a, b));
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0; norm = 0; rem_seen = -1;
    while (!out_valid && lat < 200) begin
      if (dut.state == NORM) norm++;
      if (dut.state == DENORM && rem_seen < 0) rem_seen = int'(dut.rem);
      @(posedge clk); #1;
      lat++;
    end
    e = sb_q.pop_front();
    chk("out_valid_reached", out_valid, 1'b1);
    chk("out_p", out_p, e.p);
    chk("latency", lat, e.lat);
    chk("norm_cycles", norm, e.norm);
    chk("rem", rem_seen, e.rem);
    chk("sa", int'(dut.sa), e.sa);
    chk("sb", int'(dut.sb), e.sb);
    first = out_p;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_out_p_stable", out_p, first);
      chk("hold_in_ready_low", in_ready, 1'b0);
      chk("hold_out_valid", out_valid, 1'b1);
    end
    x0 = xfers;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("one_transfer", xfers, x0 + 1);
    chk("out_valid_dropped", out_valid, 1'b0);
    chk("in_ready_after_out", in_ready, 1'b1);
    got = first;
  endtask

  initial begin
    logic [PW-1:0] got;
    int            guard, x0;
    logic          saw_valid;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_busy", busy, 1'b0);

    // Already-normalized operands: no shifts, full 16-step denormalize, 19-cycle latency.
    run_pair(16'h8000, 16'h8000, 0, got);
    chk("vec_8000x8000", got, 32'h4000_0000);

    // Six shifts each; the product is exact.
    run_pair(16'h0300, 16'h0200, 0, got);
    chk("vec_0300x0200", got, 32'h0006_0000);

    // Zero operand saturates its count and forces a zero product.
    run_pair(16'h0000, 16'h1234, 0, got);
    chk("vec_zero_a", got, 32'h0);

    // Truncation vs round-half-up on the first dropped bit.
    run_pair(16'h81C0, 16'h8000, 0, got);
`ifdef APPROX_MULT_ROUND_EN
    chk("vec_81C0_round", got, 32'h4100_0000);
`else
    chk("vec_81C0_trunc", got, 32'h4080_0000);
`endif

    // Backpressure: result parked in OUT for 5 cycles.
    run_pair(16'hABCD, 16'h0F0F, 5, got);

    // Both operands tiny, both saturate.
    run_pair(16'h0001, 16'h0003, 0, got);
    chk("vec_tiny_zero", got, 32'h0);

    // Abort mid-DENORM with a one-cycle reset.
    x0 = xfers;
    saw_valid = 1'b0;
    in_a = 16'h8000; in_b = 16'h8000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    guard = 0;
    while (dut.state != DENORM && guard < 50) begin @(posedge clk); #1; guard++; end
    chk("reached_denorm", (dut.state == DENORM), 1'b1);
    repeat (4) begin @(posedge clk); #1; if (out_valid) saw_valid = 1'b1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_in_ready", in_ready, 1'b1);
    chk("abort_busy", busy, 1'b0);
    chk("abort_idle", (dut.state == IDLE), 1'b1);
    out_ready = 1'b1;
    repeat (25) begin @(posedge clk); #1; if (out_valid) saw_valid = 1'b1; end
    out_ready = 1'b0;
    chk("abort_no_out_valid", saw_valid, 1'b0);
    chk("abort_no_transfer", xfers, x0);

    run_pair(16'h0300, 16'h0200, 0, got);
    chk("after_abort_vec", got, 32'h0006_0000);

    // A few random pairs against the reference model.
    for (int k = 0; k < 6; k++) begin
      run_pair(DW'($urandom_range(0, 16'hFFFF)), DW'($urandom_range(0, 16'hFFFF)), k % 2, got);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/approx_mult_stream.md
APPROX_MULT_STREAM -- requirements
Module: approx_mult_stream

Interface
REQ-001 The module SHALL expose parameter DATA_W, default 16, which sets the operand width in bits.
REQ-002 The module SHALL expose parameter KEEP_W, default 8, which sets the number of normalized MSBs kept for the multiply.
REQ-003 The module SHALL expose parameter SHIFT_MAX, default 7, which sets the maximum normalization shift per operand; legal range is 0 < SHIFT_MAX <= DATA_W-KEEP_W.
REQ-004 The module SHALL have the port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-005 The module SHALL have the port rst, input, 1 bit, a synchronous active-high reset.
REQ-006 The module SHALL have the port in_valid, input, 1 bit, meaning the operand pair is valid.
REQ-007 The module SHALL have the port in_ready, output, 1 bit, meaning the block accepts a pair.
REQ-008 The module SHALL have the port in_a, input, DATA_W bits, operand A (unsigned).
REQ-009 The module SHALL have the port in_b, input, DATA_W bits, operand B (unsigned).
REQ-010 The module SHALL have the port out_valid, output, 1 bit, meaning the result is valid.
REQ-011 The module SHALL have the port out_ready, input, 1 bit, meaning downstream accepts the result.
REQ-012 The module SHALL have the port out_p, output, 2*DATA_W bits, the approximate product.
REQ-013 The module SHALL have the port busy, output, 1 bit, high in every state except IDLE.

Function
REQ-014 FSM states SHALL be IDLE, NORM, MUL, DENORM and OUT; in_ready SHALL equal (state==IDLE), and out_valid SHALL equal (state==OUT).
REQ-015 IDLE: on in_valid&&in_ready the block SHALL load in_a and in_b into shift registers, clear counters sa and sb, and move to NORM.
REQ-016 NORM, per operand x: done_x SHALL equal reg_x[MSB] | (cnt_x==SHIFT_MAX); when done_x is low the block SHALL shift reg_x left 1 (zero fill) and increment cnt_x; both operands SHALL be handled in the same cycle; when done_a&&done_b the block SHALL move to MUL; NORM SHALL last max(sa,sb)+1 cycles.
REQ-017 MUL (1 cycle): ta and tb SHALL be reg[DATA_W-1 -: KEEP_W]; the product register SHALL load ta*tb zero-extended to 2*DATA_W; rem SHALL load 2*(DATA_W-KEEP_W)-sa-sb, which is never negative.
REQ-018 DENORM: if rem==0 the block SHALL move to OUT, else it SHALL shift the product register left 1 and decrement rem; DENORM SHALL last rem+1 cycles.
REQ-019 OUT: out_p SHALL hold stable until out_valid&&out_ready, then the block SHALL return to IDLE; a new pair SHALL NOT be accepted in that same cycle.
REQ-020 Latency from the accept edge to out_valid high SHALL be (max(sa,sb)+1)+1+(rem+1) cycles.
REQ-021 A zero operand SHALL saturate its count at SHIFT_MAX and yield out_p=0.
REQ-022 When out_valid is high, out_p SHALL equal ((ta*tb) << 2*(DATA_W-KEEP_W)) >> (sa+sb); while out_valid is low, out_p is don't-care.

Reset
REQ-023 While rst is high, state SHALL go to IDLE and all registers and counters SHALL clear; out_valid=0, busy=0 and in_ready=1 from the first cycle after rst deasserts.
REQ-024 rst in any state SHALL abort the operation in flight and drop its result.

Configuration
REQ-025 With APPROX_MULT_ROUND_EN defined, ta and tb SHALL be round-half-up: the kept bits plus the bit directly below them, saturating at all-ones.
REQ-026 With APPROX_MULT_ROUND_EN not defined, ta and tb SHALL be plain truncation; latency SHALL be identical in both builds.

Structure
REQ-027 A shared package approx_mult_pkg SHALL hold the state enum and the derived widths: CNT_W = clog2(SHIFT_MAX+1) and REM_W = clog2(2*(DATA_W-KEEP_W)+1).
REQ-028 The design SHALL use one sub-module, approx_norm_unit, instantiated twice (shift register, counter and done logic per operand).

Verification
REQ-029 The bench SHALL drive a=0x8000, b=0x8000 and check sa=sb=0, rem=16, out_p=0x40000000, with out_valid on the 19th edge after accept.
REQ-030 The bench SHALL drive a=0x0300, b=0x0200 and check sa=sb=6, rem=4, out_p=0x00060000 (exact).
REQ-031 The bench SHALL drive a=0x0000, b=0x1234 and check out_p=0, with NORM lasting SHIFT_MAX+1 cycles.
REQ-032 The bench SHALL drive a=0x81C0, b=0x8000 and check out_p=0x40800000 without the macro and 0x41000000 with APPROX_MULT_ROUND_EN.
REQ-033 The bench SHALL hold out_ready=0 for 5 cycles in OUT and check that out_p is stable, in_ready=0, and exactly one transfer occurs.
REQ-034 The bench SHALL assert rst for one cycle mid-DENORM and check IDLE with in_ready=1 on the next cycle, out_valid never high, and the next pair computed correctly.
